// File: rtl/fifo_nibble_tx_if.sv
// FIFO read-side handshake between the nibble FIFO and its serial drain.
// The FIFO is first-word-fall-through: rdata is the head whenever empty is 0.
interface fifo_nibble_tx_if;
  logic [3:0] rdata;
  logic       empty;
  logic       ren;

  // Transmitter side: pops words.
  modport master (output ren, input rdata, input empty);
  // FIFO side: presents the head word and honours pops.
  modport slave  (input ren, output rdata, output empty);
endinterface

// File: rtl/fifo_nibble_tx.sv
// Drains 4-bit words from a FWFT FIFO and sends each as a 6-bit serial frame:
// start (0), d0..d3 LSB first, stop (1). One pop per frame; back-to-back
// frames chain straight from the last stop cycle into the next start bit.
module fifo_nibble_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             CLK,
  input  logic             RESETN,
  fifo_nibble_tx_if.master fifo,
  output logic             tx,
  output logic             busy
);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 255) begin : g_bad_cpb
    $error("fifo_nibble_tx: CLKS_PER_BIT must be in 2..255");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLKS_PER_BIT - 1);

  state_t     state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [1:0] bit_q, bit_d;
  logic [3:0] shift_q, shift_d;
  logic       tx_q, tx_d;
  logic       last_cycle;
  logic       pop;

  assign last_cycle = (div_q == DIV_LAST);

  // Pop only from IDLE or on the final stop cycle, so a frame in flight is
  // never disturbed; gating with RESETN keeps ren low while reset is held.
  assign pop = ~fifo.empty & RESETN &
               ((state_q == IDLE) | ((state_q == STOP) & last_cycle));

  assign fifo.ren = pop;
  assign tx       = tx_q;
  assign busy     = (state_q != IDLE);

  // Next-state: divider, bit index, shifter and frame sequencing.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    if (state_q != IDLE) div_d = last_cycle ? 8'd0 : div_q + 8'd1;
    case (state_q)
      START: begin
        if (last_cycle) begin
          state_d = DATA;
          bit_d   = 2'd0;
        end
      end
      DATA: begin
        if (last_cycle) begin
          shift_d = {1'b0, shift_q[3:1]};
          bit_d   = bit_q + 2'd1;
          if (bit_q == 2'd3) state_d = STOP;
        end
      end
      STOP: begin
        if (last_cycle) state_d = IDLE;
      end
      default: ;
    endcase
    // A pop overrides the STOP->IDLE exit so the next start bit follows at once.
    if (pop) begin
      state_d = START;
      div_d   = 8'd0;
      shift_d = fifo.rdata;
    end
  end

  // Line level follows the next state so tx moves on the same edge as the FSM.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // State registers; reset drops any word in flight and returns the line high.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= IDLE;
      div_q   <= 8'd0;
      bit_q   <= 2'd0;
      shift_q <= 4'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_fifo_nibble_tx.sv
// Three transmitters (CLKS_PER_BIT = 4, 16, 2), each fed by a FWFT FIFO model.
// A frame-level model per lane predicts tx/busy/ren every cycle; directed
// tests pin frame patterns, pop spacing and decoded words with literals.
module tb_fifo_nibble_tx;

  logic clk = 1'b0;
  logic rstn;
  int   cyc = 0;
  int   errors = 0;
  int   nchk = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO contents: written by the stimulus only, read pointer owned per lane.
  logic [3:0] fmem [3][64];
  int         wp [3];

  logic [2:0] tx_w, busy_w, ren_w, emp_w;
  logic [2:0] exp_tx_w, exp_busy_w, exp_ren_w;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_lane
    localparam int CPB  = (g == 0) ? 4 : ((g == 1) ? 16 : 2);
    localparam int FLEN = 6 * CPB;

    fifo_nibble_tx_if u_if ();
    logic txo, busyo;
    int   rp = 0;

    assign u_if.empty  = (wp[g] == rp);
    assign u_if.rdata  = fmem[g][rp[5:0]];

    fifo_nibble_tx #(.CLKS_PER_BIT(CPB)) u_dut (
      .CLK    (clk),
      .RESETN (rstn),
      .fifo   (u_if),
      .tx     (txo),
      .busy   (busyo)
    );

    assign tx_w[g]   = txo;
    assign busy_w[g] = busyo;
    assign ren_w[g]  = u_if.ren;
    assign emp_w[g]  = u_if.empty;

    // Frame model: in_frame with k = cycles since the start bit began.
    bit         in_frame = 1'b0;
    int         k = 0;
    logic [3:0] word = 4'd0;
    int         idx;
    bit         m_pop = 1'b0, d_pop = 1'b0, rst_low = 1'b1;

    assign idx = k / CPB;
    assign exp_ren_w[g]  = rstn && !u_if.empty && (!in_frame || k == FLEN - 1);
    assign exp_busy_w[g] = rstn && in_frame;
    assign exp_tx_w[g]   = (!rstn || !in_frame) ? 1'b1 :
                           (idx == 0) ? 1'b0 : (idx >= 5) ? 1'b1 : word[idx - 1];

    // Receive decoder and rx log.
    logic [3:0] rx_w [16];
    int         rx_n = 0;
    bit         dec_on = 1'b0;
    int         ds = 0;
    logic [3:0] dw = 4'd0;

    always @(negedge clk) begin
      m_pop   = exp_ren_w[g];
      d_pop   = u_if.ren;
      rst_low = !rstn;
      if (!rstn) dec_on = 1'b0;
      else begin
        if (dec_on) ds++;
        else if (txo == 1'b0) begin dec_on = 1'b1; ds = 0; end
        if (dec_on) begin
          if ((ds % CPB) == CPB / 2 && ds / CPB >= 1 && ds / CPB <= 4) dw[ds / CPB - 1] = txo;
          if (ds == FLEN - 1) begin
            if (rx_n < 16) rx_w[rx_n] = dw;
            rx_n++;
            dec_on = 1'b0;
          end
        end
      end
    end

    always @(posedge clk) begin
      #1;
      if (rst_low) in_frame = 1'b0;
      else if (m_pop) begin
        word = fmem[g][rp[5:0]];
        in_frame = 1'b1;
        k = 0;
      end else if (in_frame) begin
        k++;
        if (k == FLEN) in_frame = 1'b0;
      end
      if (d_pop) rp++;
    end
  end

  // Single compare process: every lane, every cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("tx lane%0d", i),   int'(tx_w[i]),   int'(exp_tx_w[i]));
      chk($sformatf("busy lane%0d", i), int'(busy_w[i]), int'(exp_busy_w[i]));
      chk($sformatf("ren lane%0d", i),  int'(ren_w[i]),  int'(exp_ren_w[i]));
    end
  end

  task automatic push(input int ln, input logic [3:0] d);
    fmem[ln][wp[ln]] = d;
    wp[ln]++;
  endtask

  task automatic wait_ren(input int ln, input int maxc, output int at);
    at = -1;
    for (int c = 0; c < maxc; c++) begin
      @(negedge clk);
      if (ren_w[ln]) begin at = cyc; break; end
    end
    if (at < 0) chk($sformatf("ren timeout lane%0d", ln), 0, 1);
  endtask

  // Follows a frame on lane ln from the cycle after the pop; bits[0] sent first.
  task automatic expect_frame(input int ln, input int cpb, input logic [5:0] bits,
                              output int busy_cnt, output int ren_cnt);
    busy_cnt = 0;
    ren_cnt  = 0;
    for (int b = 0; b < 6; b++)
      for (int c = 0; c < cpb; c++) begin
        @(negedge clk);
        chk($sformatf("frame lane%0d bit%0d", ln, b), int'(tx_w[ln]), int'(bits[b]));
        if (busy_w[ln]) busy_cnt++;
        if (ren_w[ln]) ren_cnt++;
      end
  endtask

  int t0, t1, c0, bc, rc;
  logic [3:0] stream [8];

  initial begin
    rstn = 1'b0;
    for (int i = 0; i < 3; i++) wp[i] = 0;
    stream = '{4'h2, 4'h7, 4'hD, 4'h0, 4'hF, 4'h1, 4'h8, 4'h5};

    // Reset with a word waiting: nothing moves until release.
    push(0, 4'hA);
    repeat (5) @(posedge clk);
    #2 rstn = 1'b1;
    c0 = cyc;
    wait_ren(0, 4, t0);
    chk("first pop after release", t0, c0);
    expect_frame(0, 4, 6'b110100, bc, rc);
    chk("reset-test frame busy", bc, 24);

    // Single word.
    @(posedge clk); #2 push(0, 4'h3);
    wait_ren(0, 4, t0);
    expect_frame(0, 4, 6'b100110, bc, rc);
    chk("single busy cycles", bc, 24);
    chk("single extra pops", rc, 0);
    @(negedge clk);
    chk("single idle tx", int'(tx_w[0]), 1);
    chk("single idle busy", int'(busy_w[0]), 0);
    chk("single fifo empty", int'(emp_w[0]), 1);

    // Back-to-back frames.
    @(posedge clk); #2;
    push(0, 4'h1); push(0, 4'hF); push(0, 4'h0); push(0, 4'h8);
    wait_ren(0, 4, t0);
    for (int n = 1; n < 4; n++) begin
      wait_ren(0, 30, t1);
      chk($sformatf("b2b spacing %0d", n), t1 - t0, 24);
      t0 = t1;
    end
    repeat (30) @(posedge clk);
    chk("rx count after b2b", g_lane[0].rx_n, 6);
    chk("rx[0]", int'(g_lane[0].rx_w[0]), 'hA);
    chk("rx[1]", int'(g_lane[0].rx_w[1]), 'h3);
    chk("rx[2]", int'(g_lane[0].rx_w[2]), 'h1);
    chk("rx[3]", int'(g_lane[0].rx_w[3]), 'hF);
    chk("rx[4]", int'(g_lane[0].rx_w[4]), 'h0);
    chk("rx[5]", int'(g_lane[0].rx_w[5]), 'h8);

    // Reset in DATA bit 2 of 4'h6: word dropped, next word popped on release.
    #2 push(0, 4'h6); push(0, 4'h9);
    wait_ren(0, 4, t0);
    repeat (14) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("reset mid tx", int'(tx_w[0]), 1);
    chk("reset mid busy", int'(busy_w[0]), 0);
    repeat (3) @(posedge clk);
    #2 rstn = 1'b1;
    c0 = cyc;
    wait_ren(0, 4, t1);
    chk("pop on release", t1, c0);
    repeat (30) @(posedge clk);
    chk("rx count after reset", g_lane[0].rx_n, 7);
    chk("rx after reset", int'(g_lane[0].rx_w[6]), 'h9);

    // Late arrival, CLKS_PER_BIT = 16: push 10 cycles into stop bit.
    #2 push(1, 4'hC);
    wait_ren(1, 4, t0);
    repeat (91) @(posedge clk);
    #2 push(1, 4'h5);
    wait_ren(1, 20, t1);
    chk("late pop spacing", t1 - t0, 96);
    @(negedge clk);
    chk("late start bit", int'(tx_w[1]), 0);
    repeat (100) @(posedge clk);
    chk("late rx count", g_lane[1].rx_n, 2);
    chk("late rx[0]", int'(g_lane[1].rx_w[0]), 'hC);
    chk("late rx[1]", int'(g_lane[1].rx_w[1]), 'h5);

    // Minimum divider streaming.
    #2 for (int i = 0; i < 8; i++) push(2, stream[i]);
    wait_ren(2, 4, t0);
    for (int n = 1; n < 8; n++) begin
      wait_ren(2, 16, t1);
      chk($sformatf("min spacing %0d", n), t1 - t0, 12);
      t0 = t1;
    end
    repeat (20) @(posedge clk);
    chk("min rx count", g_lane[2].rx_n, 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("min rx[%0d]", i), int'(g_lane[2].rx_w[i]), int'(stream[i]));

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, nchk);
    $finish;
  end

endmodule

// File: doc/fifo_nibble_tx.md
# fifo_nibble_tx

Serial transmitter that drains 4-bit words from the upstream nibble FIFO and sends each one on a single output line as a 6-bit frame: start bit, 4 data bits LSB-first, stop bit. It sits directly downstream of the FIFO, driving the FIFO's `ren` and consuming its `rdata` and `empty`. It pops exactly one word per frame and never pops while a frame is in flight.

## Interface
- `CLKS_PER_BIT`, default 4: clock cycles per serial bit. Legal range is 2..255; elaboration fails outside that range.
- `CLK`, input, 1 bit: rising-edge clock shared with the FIFO.
- `RESETN`, input, 1 bit: reset, asynchronous and active-low.
- `rdata`, input, 4 bits: FIFO head word. It is valid combinationally whenever `empty` is 0 (first-word-fall-through).
- `empty`, input, 1 bit: FIFO empty flag.
- `ren`, output, 1 bit: pop request to the FIFO. It is a combinational single-cycle pulse.
- `tx`, output, 1 bit: serial line. It idles high and is registered.
- `busy`, output, 1 bit: high while a frame is in flight (states START, DATA, STOP).

## Operation
- States:
  - IDLE: `tx` = 1.
  - START: `tx` = 0.
  - DATA: `tx` = `shift[0]`.
  - STOP: `tx` = 1.
- `ren` = `~empty & RESETN & (state==IDLE | (state==STOP & last_cycle))`. `last_cycle` means the divider count equals `CLKS_PER_BIT`-1.
- Pop: in any cycle where `ren` is 1:
  - `rdata` is captured into the 4-bit `shift` register on that same edge.
  - The FSM goes to START with the divider cleared.
  - The FIFO advances its read pointer on the same edge.
- Divider: counts 0..`CLKS_PER_BIT`-1 in START, DATA and STOP. On reaching the terminal count it wraps to 0 and the bit advances.
- START → DATA after `CLKS_PER_BIT` cycles; the bit index is cleared to 0.
- DATA: on each terminal count, `shift` shifts right by one and the bit index increments (2-bit counter). After bit index 3 completes, the FSM goes to STOP.
- STOP → IDLE after `CLKS_PER_BIT` cycles if `empty` = 1. If `empty` = 0, the FSM goes directly to START with a new pop, so back-to-back frames have no idle gap.
- The `tx` register is loaded from the next-state value, so the `tx` level changes on the same edge as the state change.
- Upstream `rdata` and `empty` are ignored outside pop cycles. Changes mid-frame do not affect the frame in flight.
- `busy` = `(state != IDLE)`.

## Timing
- Reset values, asserted asynchronously and held while `RESETN` = 0:
  - state = IDLE
  - `tx` = 1
  - `busy` = 0
  - `ren` = 0
  - `shift` = 0
  - divider = 0
  - bit index = 0
- Reset mid-frame: `tx` returns high immediately and the popped word is discarded. After reset release, the first possible pop is in the first cycle with `RESETN` = 1 and `empty` = 0.
- Latency: `tx` falls on the edge that ends the pop cycle (1 cycle after `ren`).
- Frame length: exactly 6×`CLKS_PER_BIT` cycles from the `tx` falling edge to the end of the stop bit.
- Continuous traffic: one pop every 6×`CLKS_PER_BIT` cycles.
- Isolated word: IDLE, then pop, then frame, then IDLE. The next pop is allowed on the cycle after return to IDLE.
- Simultaneous events:
  - `empty` deasserting on the last STOP cycle causes a pop in that cycle.
  - `empty` deasserting on any earlier STOP cycle has no effect until the last STOP cycle.
- `ren` is never 1 while `empty` = 1, and is never 1 for two consecutive cycles.

## Test plan
- **Reset:** hold `RESETN` = 0 with `empty` = 0 and `rdata` = 4'hA.
  - Required: `tx` = 1, `busy` = 0 and `ren` = 0 throughout.
  - After release (`CLKS_PER_BIT` = 4): `ren` pulses in the first cycle, then `tx` shows 0,0,1,0,1,1 for 4 cycles each.
- **Single word:** push 4'h3 into an empty FIFO.
  - Required: exactly one `ren` pulse.
  - `tx` sequence 0,1,1,0,0,1, 4 cycles each (24 cycles total).
  - `busy` high for exactly 24 cycles, then `tx` = 1 and `empty` = 1.
- **Back-to-back, no gap:** preload 4'h1, 4'hF, 4'h0, 4'h8.
  - Required: 4 `ren` pulses spaced 24 cycles apart.
  - No high idle cycle between one frame's stop bit and the next frame's start bit.
  - Decoded words are 1, F, 0, 8 in order.
- **Late arrival:** push 4'h5 into the FIFO 10 cycles into the STOP bit of a 4'hC frame with `CLKS_PER_BIT` = 16.
  - Required: pop on the last STOP cycle and an immediate start bit.
- **Reset mid-frame:** assert `RESETN` = 0 during DATA bit 2 of 4'h6.
  - Required: `tx` = 1 immediately; the word is not retransmitted.
  - The next FIFO word is popped on the first cycle after release.
- **Minimum divider:** `CLKS_PER_BIT` = 2, stream 8 words.
  - Required: 12-cycle frames.
  - Every transmitted word matches the FIFO write order.
  - `ren` is never asserted while `empty` = 1.
